// File: rtl/mips_pkg.sv
// Shared constants and state encoding for the boot-time instruction-memory loader.
package mips_pkg;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CNT_W      = 8 * HDR_BYTES;
    localparam int unsigned LANE_W     = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        StHdrHi,
        StHdrLo,
        StData,
        StChk,
        StDone,
        StErr
    } ld_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_word_asm.sv
// Assembles big-endian bytes into 32-bit words; word_done flags the completing byte.
module imem_word_asm
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic        word_done,
    output logic [31:0] word_next
);

    logic [LANE_W-1:0] lane_q;
    logic [31:0]       word_q;

    assign word_next = {word_q[23:0], byte_in};
    assign word_done = en && (lane_q == LANE_W'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
            word_q <= '0;
        end else if (en) begin
            lane_q <= lane_q + 1'b1;
            word_q <= word_next;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a counted, XOR-checksummed program into instruction memory, then releases the core.
module imem_loader
    import mips_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          done,
    output logic          err
);

    if (ADDR_W != $clog2(IMEM_WORDS)) begin : g_bad_addr_w
        $error("ADDR_W must equal clog2(IMEM_WORDS)");
    end

    ld_state_e         state_q;
    logic [7:0]        cnt_hi_q;
    logic [CNT_W-1:0]  n_q;
    logic [ADDR_W-1:0] idx_q;
    logic [7:0]        csum_q;
    logic              rx_ready_q, imem_we_q, cpu_reset_q, done_q, err_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;

    logic              acc;
    logic [CNT_W-1:0]  hdr_n;
    logic              last_word;
    logic              word_done;
    logic [31:0]       word_next;

    assign acc       = bus.rx_valid && rx_ready_q;
    assign hdr_n     = {cnt_hi_q, bus.rx_data};
    assign last_word = (CNT_W'(idx_q) + CNT_W'(1)) == n_q;

    imem_word_asm u_word_asm (
        .clk       (clk),
        .reset     (reset),
        .en        (acc && (state_q == StData)),
        .byte_in   (bus.rx_data),
        .word_done (word_done),
        .word_next (word_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StHdrHi;
            cnt_hi_q     <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            csum_q       <= '0;
            rx_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            if (acc) begin
                unique case (state_q)
                    StHdrHi: begin
                        cnt_hi_q <= bus.rx_data;
                        csum_q   <= csum_q ^ bus.rx_data;
                        state_q  <= StHdrLo;
                    end
                    StHdrLo: begin
                        n_q    <= hdr_n;
                        csum_q <= csum_q ^ bus.rx_data;
                        if (hdr_n == '0) begin
                            state_q <= StChk;
                        end else if (hdr_n > CNT_W'(IMEM_WORDS)) begin
                            state_q    <= StErr;
                            err_q      <= 1'b1;
                            rx_ready_q <= 1'b0;
                        end else begin
                            state_q <= StData;
                        end
                    end
                    StData: begin
                        csum_q <= csum_q ^ bus.rx_data;
                        if (word_done) begin
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= idx_q;
                            imem_wdata_q <= word_next;
                            idx_q        <= idx_q + 1'b1;
                            if (last_word) state_q <= StChk;
                        end
                    end
                    StChk: begin
                        rx_ready_q <= 1'b0;
                        if (bus.rx_data == csum_q) begin
                            state_q     <= StDone;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
                        end else begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign cpu_reset      = cpu_reset_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good, gapped, bad-checksum, oversize, empty and aborted loads.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cpu_reset, done, err;

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(
        .IMEM_WORDS (256),
        .ADDR_W     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    int both_cnt = 0;
    int rdy_drops = 0;
    logic [7:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    logic [7:0]  stream [$];

    // Write log: every high cycle of imem_we is one entry, so a stretched strobe shows up.
    always @(negedge clk) begin
        if (bus.imem_we) begin
            if (wr_total < 64) begin
                wr_addr[wr_total] = bus.imem_addr;
                wr_data[wr_total] = bus.imem_wdata;
            end
            wr_total = wr_total + 1;
        end
        if (done && err) both_cnt = both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_stream(input int gap);
        for (int i = 0; i < stream.size(); i++) begin
            bus.rx_data  = stream[i];
            bus.rx_valid = 1'b1;
            @(posedge clk);
            #1 bus.rx_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                if (i < stream.size() - 1 && !bus.rx_ready) rdy_drops = rdy_drops + 1;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_single(input string tag, input int base);
        check({tag, "_nwr"}, 32'(wr_total - base), 32'd1);
        check({tag, "_addr"}, {24'd0, wr_addr[base]}, 32'd0);
        check({tag, "_wdata"}, wr_data[base], 32'h2002_0005);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_cpurst"}, {31'd0, cpu_reset}, 32'd0);
        check({tag, "_ready"}, {31'd0, bus.rx_ready}, 32'd0);
    endtask

    int base;

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        do_reset();
        check("rst_ready", {31'd0, bus.rx_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_cpurst", {31'd0, cpu_reset}, 32'd1);
        check("rst_we", {31'd0, bus.imem_we}, 32'd0);
        check("rst_addr", {24'd0, bus.imem_addr}, 32'd0);
        check("rst_wdata", bus.imem_wdata, 32'd0);

        // One word, back-to-back, then a stray byte in DONE.
        base = wr_total;
        stream = '{8'h00, 8'h01, 8'h20, 8'h02, 8'h00, 8'h05, 8'h26};
        send_stream(0);
        check_single("b2b", base);
        stream = '{8'h33};
        send_stream(2);
        check("b2b_stray_done", {31'd0, done}, 32'd1);
        check("b2b_stray_nwr", 32'(wr_total - base), 32'd1);

        // Same stream with 3 idle cycles between bytes.
        do_reset();
        base = wr_total;
        rdy_drops = 0;
        stream = '{8'h00, 8'h01, 8'h20, 8'h02, 8'h00, 8'h05, 8'h26};
        send_stream(3);
        check_single("gap", base);
        check("gap_ready_drops", 32'(rdy_drops), 32'd0);

        // Two words, bad checksum (correct would be 0x21).
        do_reset();
        base = wr_total;
        stream = '{8'h00, 8'h02, 8'h8C, 8'h03, 8'h00, 8'h00,
                   8'hAC, 8'h04, 8'h00, 8'h04, 8'hFF};
        send_stream(0);
        check("bad_nwr", 32'(wr_total - base), 32'd2);
        check("bad_addr0", {24'd0, wr_addr[base]}, 32'd0);
        check("bad_wdata0", wr_data[base], 32'h8C03_0000);
        check("bad_addr1", {24'd0, wr_addr[base+1]}, 32'd1);
        check("bad_wdata1", wr_data[base+1], 32'hAC04_0004);
        check("bad_err", {31'd0, err}, 32'd1);
        check("bad_done", {31'd0, done}, 32'd0);
        check("bad_cpurst", {31'd0, cpu_reset}, 32'd1);
        check("bad_ready", {31'd0, bus.rx_ready}, 32'd0);

        // Oversize header N = 257.
        do_reset();
        base = wr_total;
        stream = '{8'h01, 8'h01};
        send_stream(0);
        check("big_err", {31'd0, err}, 32'd1);
        check("big_ready", {31'd0, bus.rx_ready}, 32'd0);
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(0);
        check("big_nwr", 32'(wr_total - base), 32'd0);
        check("big_done", {31'd0, done}, 32'd0);

        // Boundary N = 256 header is legal: stays in DATA.
        do_reset();
        stream = '{8'h01, 8'h00};
        send_stream(0);
        check("n256_err", {31'd0, err}, 32'd0);
        check("n256_ready", {31'd0, bus.rx_ready}, 32'd1);

        // Empty program, good then bad checksum.
        do_reset();
        base = wr_total;
        stream = '{8'h00, 8'h00, 8'h00};
        send_stream(0);
        check("empty_done", {31'd0, done}, 32'd1);
        check("empty_cpurst", {31'd0, cpu_reset}, 32'd0);
        check("empty_nwr", 32'(wr_total - base), 32'd0);
        do_reset();
        stream = '{8'h00, 8'h00, 8'h01};
        send_stream(0);
        check("empty_bad_err", {31'd0, err}, 32'd1);
        check("empty_bad_done", {31'd0, done}, 32'd0);

        // Abort mid-word, then a full restart.
        do_reset();
        base = wr_total;
        stream = '{8'h00, 8'h01, 8'h20, 8'h02};
        send_stream(0);
        do_reset();
        check("abort_we", {31'd0, bus.imem_we}, 32'd0);
        check("abort_nwr", 32'(wr_total - base), 32'd0);
        check("abort_ready", {31'd0, bus.rx_ready}, 32'd1);
        stream = '{8'h00, 8'h01, 8'h20, 8'h02, 8'h00, 8'h05, 8'h26};
        send_stream(0);
        check_single("restart", base);

        check("done_err_overlap", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
